arm_level_modulator: RTL and testbench
======================================

Name: arm_level_modulator

Overview:
- Per-arm nearest-level PWM modulator for the 2-cell half-bridge MMC arm.
- Converts an unsigned arm-voltage reference into the 3-bit `vc_level` code (0=−2Vdc … 2=0 … 4=+2Vdc) and the `period_flag` strobe.
- The arm capacitor-balancing block consumes both signals and latches `vc_level` on `period_flag`.
- Sits between the per-arm reference generator and the balancing block, one instance per arm.

Parameters:
- PER_W, 8, log2 of switching period in clk cycles (PERIOD = 2^PER_W).
- MIN_ON, 4, minimum dwell in cycles at either level within a period; shorter pulses are dropped.
- REF_W, 11, reference width; 256 LSB = one level step.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  modulator enable
- ref  in  REF_W  arm reference, unsigned, 0..1024 valid; values >1024 clamp to 1024
- vc_level  out  3  level code, registered
- period_flag  out  1  one-cycle strobe; `vc_level` is valid and stable in the same cycle
- period_start  out  1  one-cycle strobe at the start of each period (ADC sync)

Behaviour:
- Reset (async, immediate): `cnt`=0, `vc_level`=2, `period_flag`=0, `period_start`=0, `base_r`=2, `hi_r`=0.
- `en`=0, at each clock edge:
  - `cnt` held at 0.
  - Both strobes are 0.
  - `vc_level` holds its last value.
- Duty calculation (combinational; evaluated on `ref` only in the cycle `cnt`=0):
  - Clamp: `r` = min(`ref`, 1024).
  - `base` = `r`[10:8]; `frac` = `r`[7:0].
  - `hi` = (`frac` × PERIOD) >> 8.
  - If `hi` < MIN_ON: `hi` = 0.
  - If `hi` > PERIOD−MIN_ON: `hi` = PERIOD.
  - If `hi` = PERIOD, use `base`+1 with `hi`=0 instead. This promotion never exceeds level 4, because `base`=4 implies `frac`=0.
- Edge with `en`=1 and `cnt`=0 (period start):
  - `base_r`/`hi_r` latch.
  - `vc_level` ← (`hi`>0 ? `base`+1 : `base`).
  - `period_flag` ← 1 and `period_start` ← 1.
  - `cnt` ← 1.
- Edge with `en`=1, `cnt` = `hi_r`, and `hi_r` ≠ 0 (mid-period transition):
  - `vc_level` ← `base_r`.
  - `period_flag` ← 1.
- All other edges:
  - Both strobes ← 0.
  - `cnt` ← `cnt`+1, wrapping from PERIOD−1 to 0.
- Flags per period: exactly 1 or 2 `period_flag` pulses; always exactly 1 `period_start`.
- Output registers:
  - `vc_level` changes only in cycles where `period_flag` is 1.
  - Latency from `cnt` state to output is 1 clk.
- Reference timing: `ref` changes mid-period are ignored until the next `cnt`=0 sample.
- `en` deassert mid-period:
  - `cnt` resets to 0 on the next edge.
  - `vc_level` holds; no flag is issued.
  - A re-enable starts a fresh period at the next edge.
- Reset mid-period: immediate return to the reset values; the first flag follows the first enabled edge after release.
- Widths: `hi` computed in PER_W+1 bits so it can hold PERIOD; `frac`×PERIOD fits in PER_W+8 bits.

Decomposition:
- Shared package `mmc_pkg`:
  - Level constants LVL_NEG2=0, LVL_NEG1=1, LVL_ZERO=2, LVL_POS1=3, LVL_POS2=4.
  - REF_STEP=256.
  - REF_MAX=1024.
- One natural sub-module: `arm_duty_calc`, purely combinational (`ref` → `base`, `hi` with clamp, MIN_ON rules and promotion).
- The top level holds the counter, latches and output registers.

Test Plan (PERIOD=256, MIN_ON=4):
- Reset with `ref`=0x280, `en`=1:
  - Flag at first edge with `vc_level`=3 and `period_start`=1.
  - Second flag 128 cycles later with `vc_level`=2.
  - Repeats every 256 cycles.
- `ref`=0x000:
  - `vc_level`=0.
  - One flag per 256 cycles; no mid flag.
- `ref`=0x7FF (clamps to 1024):
  - `vc_level`=4.
  - Exactly one flag per period.
- MIN_ON boundaries:
  - `ref`=0x102 (`frac`=2): `vc_level`=1 all period, no mid flag.
  - `ref`=0x1FE (`frac`=254): `vc_level`=2 all period, no mid flag.
- Mid-period reference change: change `ref` 0x180→0x300 at `cnt`=50.
  - Current period still transitions 2→1 at `cnt`=128.
  - Next period outputs 3, single flag.
- Enable and async reset:
  - Drop `en` at `cnt`=100: no further flags, `vc_level` held; re-assert gives a flag on the next edge.
  - Assert `rst` asynchronously mid-period: `vc_level`=2 and flags 0 before the next clk edge.

Source files
------------

// File: rtl/mmc_pkg.sv
// ----------------------------------------------------------------------------
// mmc_pkg
// Shared constants for the 2-cell half-bridge MMC arm blocks.
//   Level codes : LVL_NEG2 (-2Vdc) .. LVL_POS2 (+2Vdc), LVL_ZERO = 0 V
//   REF_STEP    : reference LSBs per level step
//   REF_MAX     : largest meaningful reference (level 4, zero fraction)
// ----------------------------------------------------------------------------
package mmc_pkg;

    localparam logic [2:0] LVL_NEG2 = 3'd0;
    localparam logic [2:0] LVL_NEG1 = 3'd1;
    localparam logic [2:0] LVL_ZERO = 3'd2;
    localparam logic [2:0] LVL_POS1 = 3'd3;
    localparam logic [2:0] LVL_POS2 = 3'd4;

    localparam int REF_STEP = 256;
    localparam int REF_MAX  = 1024;

endpackage

// File: rtl/arm_level_modulator_if.sv
// ----------------------------------------------------------------------------
// arm_level_modulator_if
// Bundle between the per-arm reference generator (master) and the arm level
// modulator (slave).
//   en           : modulator enable                     (master -> slave)
//   arm_ref      : unsigned arm reference, REF_W bits   (master -> slave)
//   vc_level     : registered 3-bit level code          (slave -> master)
//   period_flag  : strobe, vc_level valid this cycle    (slave -> master)
//   period_start : strobe at start of each period       (slave -> master)
// ----------------------------------------------------------------------------
interface arm_level_modulator_if #(
    parameter int REF_W = 11
) ();

    logic             en;
    logic [REF_W-1:0] arm_ref;
    logic [2:0]       vc_level;
    logic             period_flag;
    logic             period_start;

    modport master (
        output en,
        output arm_ref,
        input  vc_level,
        input  period_flag,
        input  period_start
    );

    modport slave (
        input  en,
        input  arm_ref,
        output vc_level,
        output period_flag,
        output period_start
    );

endinterface

// File: rtl/arm_duty_calc.sv
// ----------------------------------------------------------------------------
// arm_duty_calc
// Purely combinational duty calculation for one switching period.
//   arm_ref : unsigned reference, clamped to REF_MAX
//   base    : lower level of the pair the period modulates between
//   hi      : cycles spent at base+1 at the start of the period (0 = none)
// Pulses shorter than MIN_ON at either level are dropped; a period that
// would sit at base+1 for the whole time is promoted to a plain base+1.
// ----------------------------------------------------------------------------
module arm_duty_calc
    import mmc_pkg::*;
#(
    parameter int PER_W  = 8,
    parameter int MIN_ON = 4,
    parameter int REF_W  = 11
) (
    input  logic [REF_W-1:0] arm_ref,
    output logic [2:0]       base,
    output logic [PER_W:0]   hi
);

    localparam int FRAC_W = $clog2(REF_STEP);

    localparam logic [REF_W-1:0] REF_MAX_V = REF_W'(REF_MAX);
    localparam logic [PER_W:0]   PERIOD_V  = (PER_W+1)'(2 ** PER_W);
    localparam logic [PER_W:0]   MIN_ON_V  = (PER_W+1)'(MIN_ON);
    localparam logic [PER_W:0]   HI_LIMIT  = PERIOD_V - MIN_ON_V;

    logic [REF_W-1:0]         r;
    logic [FRAC_W-1:0]        frac;
    logic [2:0]               base_raw;
    logic [PER_W+FRAC_W-1:0]  prod;
    logic [PER_W:0]           hi_raw;

    // The fraction scaled to the period length is the raw high-level dwell.
    // Too-short high pulses vanish; too-short low pulses turn the whole
    // period into the upper level, expressed as base+1 with no transition.
    always_comb begin
        r        = (arm_ref > REF_MAX_V) ? REF_MAX_V : arm_ref;
        frac     = r[FRAC_W-1:0];
        base_raw = r[FRAC_W+2:FRAC_W];
        prod     = {frac, {PER_W{1'b0}}};
        hi_raw   = (PER_W+1)'(prod >> FRAC_W);

        base = base_raw;
        hi   = hi_raw;
        if (hi_raw < MIN_ON_V) begin
            hi = '0;
        end else if (hi_raw > HI_LIMIT) begin
            base = base_raw + 3'd1;
            hi   = '0;
        end
    end

endmodule

// File: rtl/arm_level_modulator.sv
// ----------------------------------------------------------------------------
// arm_level_modulator
// Per-arm nearest-level PWM modulator. Each 2^PER_W-cycle period starts at
// base+1 for hi cycles (if hi > 0), then drops to base for the remainder.
//   clk  : system clock
//   rst  : asynchronous reset, active-high
//   bus  : arm_level_modulator_if.slave
//          en, arm_ref in; vc_level, period_flag, period_start out
// vc_level only changes in cycles where period_flag is high, so the
// balancing block can latch it on the flag.
// ----------------------------------------------------------------------------
module arm_level_modulator
    import mmc_pkg::*;
#(
    parameter int PER_W  = 8,
    parameter int MIN_ON = 4,
    parameter int REF_W  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    arm_level_modulator_if.slave  bus
);

    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] cnt_d;
    logic [2:0]       vc_q;
    logic [2:0]       vc_d;
    logic [2:0]       base_r;
    logic [2:0]       base_d;
    logic [PER_W:0]   hi_r;
    logic [PER_W:0]   hi_d;
    logic             flag_q;
    logic             flag_d;
    logic             start_q;
    logic             start_d;

    logic [2:0]       base_calc;
    logic [PER_W:0]   hi_calc;

    arm_duty_calc #(
        .PER_W  (PER_W),
        .MIN_ON (MIN_ON),
        .REF_W  (REF_W)
    ) u_duty (
        .arm_ref (bus.arm_ref),
        .base    (base_calc),
        .hi      (hi_calc)
    );

    // Period sequencing. The reference is only sampled when cnt is 0, so a
    // reference change mid-period waits for the next period. Disabling
    // parks the counter at 0 so re-enabling starts a fresh period at once.
    always_comb begin
        cnt_d   = cnt_q;
        vc_d    = vc_q;
        base_d  = base_r;
        hi_d    = hi_r;
        flag_d  = 1'b0;
        start_d = 1'b0;

        if (!bus.en) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            base_d  = base_calc;
            hi_d    = hi_calc;
            vc_d    = (hi_calc != '0) ? base_calc + 3'd1 : base_calc;
            flag_d  = 1'b1;
            start_d = 1'b1;
            cnt_d   = PER_W'(1);
        end else begin
            if ((hi_r != '0) && ({1'b0, cnt_q} == hi_r)) begin
                vc_d   = base_r;
                flag_d = 1'b1;
            end
            cnt_d = cnt_q + PER_W'(1);
        end
    end

    // State and output registers; reset parks the arm at the zero level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            vc_q    <= LVL_ZERO;
            base_r  <= LVL_ZERO;
            hi_r    <= '0;
            flag_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            vc_q    <= vc_d;
            base_r  <= base_d;
            hi_r    <= hi_d;
            flag_q  <= flag_d;
            start_q <= start_d;
        end
    end

    assign bus.vc_level     = vc_q;
    assign bus.period_flag  = flag_q;
    assign bus.period_start = start_q;

endmodule

// File: tb/tb_arm_level_modulator.sv
// ----------------------------------------------------------------------------
// tb_arm_level_modulator
// Drives arm_level_modulator with directed and random references and compares
// every cycle against a period-level reference model kept in the bench.
// ----------------------------------------------------------------------------
module tb_arm_level_modulator;

    localparam int PER_W  = 8;
    localparam int MIN_ON = 4;
    localparam int REF_W  = 11;
    localparam int PERIOD = 1 << PER_W;

    logic clk = 1'b0;
    logic rst;

    arm_level_modulator_if #(.REF_W(REF_W)) bus ();

    arm_level_modulator #(
        .PER_W  (PER_W),
        .MIN_ON (MIN_ON),
        .REF_W  (REF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int errCount   = 0;
    int checkCount = 0;
    bit cmpOn      = 1'b0;

    // Model state: expected outputs plus position within the period
    // (mdlPos is the count the next edge will see; 0 = next edge starts).
    int mdlLvl    = 2;
    int mdlFlag   = 0;
    int mdlStart  = 0;
    int mdlPos    = 0;
    int mdlLate   = 2;
    int mdlSwitch = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Period plan from the reference in plain arithmetic: the level at the
    // start, the level after the switch, and the count where it switches.
    function automatic void planPeriod(input int refV, output int firstLvl,
                                       output int lateLvl, output int switchAt);
        int r, b, f, h;
        r = (refV > 1024) ? 1024 : refV;
        b = r / 256;
        f = r % 256;
        h = (f * PERIOD) / 256;
        if (h < MIN_ON) h = 0;
        else if (h > PERIOD - MIN_ON) h = PERIOD;
        if (h == 0) begin
            firstLvl = b; lateLvl = b; switchAt = 0;
        end else if (h == PERIOD) begin
            firstLvl = b + 1; lateLvl = b + 1; switchAt = 0;
        end else begin
            firstLvl = b + 1; lateLvl = b; switchAt = h;
        end
    endfunction

    // Reference model, advanced on every active edge and on reset.
    always @(posedge clk or posedge rst) begin
        int firstLvl, lateLvl, switchAt;
        if (rst) begin
            mdlLvl = 2; mdlFlag = 0; mdlStart = 0; mdlPos = 0;
            mdlLate = 2; mdlSwitch = 0;
        end else if (!bus.en) begin
            mdlFlag = 0; mdlStart = 0; mdlPos = 0;
        end else if (mdlPos == 0) begin
            planPeriod(int'(bus.arm_ref), firstLvl, lateLvl, switchAt);
            mdlLvl = firstLvl; mdlLate = lateLvl; mdlSwitch = switchAt;
            mdlFlag = 1; mdlStart = 1; mdlPos = 1;
        end else begin
            mdlFlag = 0; mdlStart = 0;
            if (mdlSwitch != 0 && mdlPos == mdlSwitch) begin
                mdlLvl  = mdlLate;
                mdlFlag = 1;
            end
            mdlPos = (mdlPos + 1) % PERIOD;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the edge.
    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("cyc_level", int'(bus.vc_level), mdlLvl);
            checkOutput("cyc_flag",  int'(bus.period_flag), mdlFlag);
            checkOutput("cyc_start", int'(bus.period_start), mdlStart);
        end
    end

    // Inputs change on the falling edge, then the bench idles for a while.
    task automatic applyStimulus(input bit enV, input int refV, input int cycles);
        bus.en      = enV;
        bus.arm_ref = REF_W'(refV);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic countFlags(output int n);
        n = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            n += int'(bus.period_flag);
        end
    endtask

    task automatic waitPos(input int target);
        bit found = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 4 && !found; i++) begin
            if (mdlPos == target) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) begin
            checkCount++;
            errCount++;
            $display("[TB] FAIL wait_pos: got timeout, expected position %0d", target);
        end
    endtask

    int n;
    int boundaryRefs [8] = '{11'h103, 11'h104, 11'h1FC, 11'h1FD, 11'h400, 11'h401, 11'h3FF, 11'h0FF};

    initial begin
        int refV;
        rst         = 1'b1;
        bus.en      = 1'b1;
        bus.arm_ref = 11'h280;
        repeat (2) @(negedge clk);
        cmpOn = 1'b1;

        // Reset state, then 0x280: 3 for 128 cycles, then 2.
        checkOutput("rst_level", int'(bus.vc_level), 2);
        checkOutput("rst_flag",  int'(bus.period_flag), 0);
        checkOutput("rst_start", int'(bus.period_start), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_level", int'(bus.vc_level), 3);
        checkOutput("first_flag",  int'(bus.period_flag), 1);
        checkOutput("first_start", int'(bus.period_start), 1);
        repeat (128) @(negedge clk);
        checkOutput("mid_level", int'(bus.vc_level), 2);
        checkOutput("mid_flag",  int'(bus.period_flag), 1);
        checkOutput("mid_start", int'(bus.period_start), 0);
        repeat (128) @(negedge clk);
        checkOutput("wrap_level", int'(bus.vc_level), 3);
        checkOutput("wrap_start", int'(bus.period_start), 1);
        countFlags(n);
        checkOutput("flags_280", n, 2);

        // Constant references including clamp and MIN_ON edges.
        applyStimulus(1'b1, 11'h000, PERIOD); waitPos(1);
        checkOutput("lvl_000", int'(bus.vc_level), 0);
        countFlags(n); checkOutput("flags_000", n, 1);
        applyStimulus(1'b1, 11'h7FF, PERIOD); waitPos(1);
        checkOutput("lvl_7ff", int'(bus.vc_level), 4);
        countFlags(n); checkOutput("flags_7ff", n, 1);
        applyStimulus(1'b1, 11'h102, PERIOD); waitPos(1);
        checkOutput("lvl_102", int'(bus.vc_level), 1);
        countFlags(n); checkOutput("flags_102", n, 1);
        applyStimulus(1'b1, 11'h1FE, PERIOD); waitPos(1);
        checkOutput("lvl_1fe", int'(bus.vc_level), 2);
        countFlags(n); checkOutput("flags_1fe", n, 1);

        // Reference change at cnt=50 only affects the following period.
        applyStimulus(1'b1, 11'h180, 0);
        waitPos(0);
        waitPos(50);
        bus.arm_ref = 11'h300;
        waitPos(129);
        checkOutput("chg_mid_level", int'(bus.vc_level), 1);
        checkOutput("chg_mid_flag",  int'(bus.period_flag), 1);
        waitPos(1);
        checkOutput("chg_next_level", int'(bus.vc_level), 3);
        checkOutput("chg_next_start", int'(bus.period_start), 1);
        countFlags(n); checkOutput("flags_300", n, 1);

        // Enable dropped at cnt=100: no flags, level held, restart on enable.
        applyStimulus(1'b1, 11'h280, 0);
        waitPos(0);
        waitPos(100);
        bus.en = 1'b0;
        countFlags(n);
        checkOutput("dis_flags", n, 0);
        checkOutput("dis_level", int'(bus.vc_level), 3);
        bus.en = 1'b1;
        @(negedge clk);
        checkOutput("reen_flag",  int'(bus.period_flag), 1);
        checkOutput("reen_start", int'(bus.period_start), 1);
        checkOutput("reen_level", int'(bus.vc_level), 3);

        // Asynchronous reset right after a period start (flags high, level 0).
        applyStimulus(1'b1, 11'h000, 0);
        waitPos(0);
        waitPos(1);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_level", int'(bus.vc_level), 2);
        checkOutput("arst_flag",  int'(bus.period_flag), 0);
        checkOutput("arst_start", int'(bus.period_start), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_flag",  int'(bus.period_flag), 1);
        checkOutput("post_rst_level", int'(bus.vc_level), 0);

        // Random references and enable patterns, checked by the model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                refV = boundaryRefs[$urandom_range(0, 7)];
            else
                refV = int'($urandom_range(0, 2047));
            applyStimulus($urandom_range(0, 7) != 0, refV, int'($urandom_range(1, 400)));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
